ysyx_210544_csr_trap_seq: RTL and testbench
===========================================

Name: ysyx_210544_csr_trap_seq

Overview:
Trap/return sequencer that owns the single read/write port of the CSR file. It multiplexes pipeline CSR instruction accesses with multi-cycle hardware sequences for machine-timer interrupt entry, ecall entry and mret. For each sequence it updates mepc, mcause and mstatus and returns a redirect PC. It sits between the execute stage, the CLINT and the CSR file.

Parameters:
XLEN, 64, data/PC width
CAUSE_MTI, 64'h8000_0000_0000_0007, mcause value for machine timer interrupt
CAUSE_ECALL_M, 64'd11, mcause value for ecall from M-mode

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_pc  in  XLEN  PC of the instruction currently in execute
i_ecall  in  1  execute instruction is ecall (level)
i_mret  in  1  execute instruction is mret (level)
i_clint_mtip  in  1  timer interrupt pending from CLINT
i_mstatus_mie  in  1  mstatus.MIE from CSR file
i_mie_mtie  in  1  mie.MTIE from CSR file
i_inst_csr_ren  in  1  pipeline CSR read request
i_inst_csr_wen  in  1  pipeline CSR write request
i_inst_csr_addr  in  12  pipeline CSR address
i_inst_csr_wdata  in  XLEN  pipeline CSR write data
o_inst_csr_rdata  out  XLEN  read data returned to pipeline
o_csr_ren  out  1  to CSR file
o_csr_wen  out  1  to CSR file
o_csr_addr  out  12  to CSR file
o_csr_wdata  out  XLEN  to CSR file
i_csr_rdata  in  XLEN  combinational read data from CSR file
o_busy  out  1  sequence in progress; pipeline holds
o_redirect_valid  out  1  one-cycle pulse: fetch jumps to o_redirect_pc
o_redirect_pc  out  XLEN  trap vector or mepc

Behaviour:
- Reset (async): state=IDLE, all outputs 0, internal mstatus/pc/cause latches 0.
- Addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
- irq = i_clint_mtip & i_mstatus_mie & i_mie_mtie.
- IDLE, acceptance priority: irq > i_ecall > i_mret > pipeline pass-through.
  - On accepting irq or ecall: latch pc=i_pc and cause (CAUSE_MTI or CAUSE_ECALL_M); next state T_RD_MST.
  - On accepting mret: next state R_RD_MST.
  - In the accepting cycle the pass-through is suppressed: o_csr_wen=0, o_csr_ren=0.
  - With no event: o_csr_* = i_inst_csr_* combinationally; o_inst_csr_rdata = i_csr_rdata; o_busy=0.
- Trap entry; one state per cycle; o_busy=1 in every non-IDLE state; o_inst_csr_rdata=0:
  - T_RD_MST: ren, addr=0x300; capture mst <= i_csr_rdata at edge.
  - T_WR_EPC: wen, addr=0x341, wdata=pc.
  - T_WR_CAUSE: wen, addr=0x342, wdata=cause.
  - T_WR_MST: wen, addr=0x300, wdata = mst with MPIE(7)=mst[3], MIE(3)=0, MPP(12:11)=2'b11; all other bits unchanged.
  - T_RD_TVEC: ren, addr=0x305; capture tgt <= {i_csr_rdata[XLEN-1:2],2'b00} (direct mode only).
  - DONE.
- Mret:
  - R_RD_MST: capture mst.
  - R_WR_MST: wdata = mst with MIE=mst[7], MPIE=1, MPP=2'b11.
  - R_RD_EPC: capture tgt = i_csr_rdata.
  - DONE.
- DONE: o_redirect_valid=1, o_redirect_pc=tgt, o_busy=1; next state IDLE. o_redirect_pc holds its value afterwards.
- Latency: accept edge → redirect pulse 6 cycles later for trap entry, 4 cycles later for mret.
- Non-IDLE states ignore i_ecall, i_mret and irq; pipeline CSR requests are not forwarded (the pipeline must hold while o_busy=1).
- irq arriving together with ecall or mret: the interrupt is taken with mepc = i_pc; the ecall/mret re-executes after the handler returns.
- irq that drops mid-sequence: the sequence still completes.
- In DONE the pass-through is still blocked; the first pipeline access is possible in the following IDLE cycle.
- Unknown states recover to IDLE.

Decomposition:
- Shared defines header holds the CSR address constants, mstatus bit indices (MIE=3, MPIE=7, MPP=12:11), the mcause constants and the state encoding (4-bit localparams).
- No sub-module; one FSM plus the output mux in a single file.

Test Plan:
- Timer IRQ: mstatus=0x1808, mie=0x80, mtvec=0x80001000, mtip=1, i_pc=0x80000040 → mepc=0x80000040, mcause=0x8000000000000007, mstatus=0x1880; redirect pulse 0x80001000 six cycles after accept; o_busy high throughout.
- Ecall: i_ecall=1, i_pc=0x80000100, mtvec=0x80002003 → mcause=11, redirect 0x80002000.
- Mret after the timer-IRQ case: mstatus=0x1880, mepc=0x80000040 → mstatus=0x1888, redirect 0x80000040 four cycles after accept.
- Priority: irq and ecall in the same cycle → mcause=0x8000000000000007. Pipeline CSR write to mscratch issued while busy → no write reaches the CSR file; o_busy=1.
- Pass-through: in IDLE with no event, csrrw to mscratch (0x340) with data 0x55 → o_csr_wen=1, addr=0x340, same cycle. Read of 0x340 → o_inst_csr_rdata=0x55.
- Reset asserted in T_WR_CAUSE → outputs 0 immediately; mcause unchanged; FSM in IDLE after release.

Source files
------------

// File: rtl/ysyx_210544_csr_trap_seq_pkg.sv
// Shared constants for the CSR trap/return sequencer.
//   - CSR addresses used by the hardware sequences
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - default mcause values for timer interrupt and M-mode ecall
//   - 4-bit state encoding of the sequencer FSM
package ysyx_210544_csr_trap_seq_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MST_MIE    = 3;
  localparam int unsigned MST_MPIE   = 7;
  localparam int unsigned MST_MPP_LO = 11;
  localparam int unsigned MST_MPP_HI = 12;

  localparam logic [63:0] CAUSE_MTI_DEFAULT     = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_ECALL_M_DEFAULT = 64'd11;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_T_RD_MST  = 4'd1;
  localparam logic [3:0] S_T_WR_EPC  = 4'd2;
  localparam logic [3:0] S_T_WR_CAU  = 4'd3;
  localparam logic [3:0] S_T_WR_MST  = 4'd4;
  localparam logic [3:0] S_T_RD_TVEC = 4'd5;
  localparam logic [3:0] S_R_RD_MST  = 4'd6;
  localparam logic [3:0] S_R_WR_MST  = 4'd7;
  localparam logic [3:0] S_R_RD_EPC  = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

endpackage

// File: rtl/ysyx_210544_csr_trap_seq.sv
// CSR trap/return sequencer.
// Owns the single CSR-file port. In IDLE the pipeline's CSR accesses pass straight
// through; a timer interrupt, ecall or mret starts a multi-cycle sequence that
// updates mepc/mcause/mstatus and ends with a one-cycle redirect pulse.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_pc                          PC of the instruction in execute
//   i_ecall, i_mret               execute-stage ecall/mret (level)
//   i_clint_mtip, i_mstatus_mie,
//   i_mie_mtie                    timer interrupt pending and enables
//   i_inst_csr_*                  pipeline CSR request
//   o_inst_csr_rdata              read data back to the pipeline
//   o_csr_*, i_csr_rdata          CSR-file port
//   o_busy                        sequence in progress, pipeline holds
//   o_redirect_valid/_pc          fetch redirect (trap vector or mepc)
module ysyx_210544_csr_trap_seq
  import ysyx_210544_csr_trap_seq_pkg::*;
#(
  parameter int unsigned      XLEN          = 64,
  parameter logic [XLEN-1:0]  CAUSE_MTI     = CAUSE_MTI_DEFAULT[XLEN-1:0],
  parameter logic [XLEN-1:0]  CAUSE_ECALL_M = CAUSE_ECALL_M_DEFAULT[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_ecall,
  input  logic            i_mret,
  input  logic            i_clint_mtip,
  input  logic            i_mstatus_mie,
  input  logic            i_mie_mtie,
  input  logic            i_inst_csr_ren,
  input  logic            i_inst_csr_wen,
  input  logic [11:0]     i_inst_csr_addr,
  input  logic [XLEN-1:0] i_inst_csr_wdata,
  output logic [XLEN-1:0] o_inst_csr_rdata,
  output logic            o_csr_ren,
  output logic            o_csr_wen,
  output logic [11:0]     o_csr_addr,
  output logic [XLEN-1:0] o_csr_wdata,
  input  logic [XLEN-1:0] i_csr_rdata,
  output logic            o_busy,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc
);

  logic [3:0]      r_state;
  logic [3:0]      w_state_d;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_mst;
  logic [XLEN-1:0] r_tgt;

  logic            w_irq;
  logic            w_take_trap;
  logic [XLEN-1:0] w_mst_trap;
  logic [XLEN-1:0] w_mst_ret;

  // Unmasked combinational outputs; reset forces the real outputs to zero.
  logic [XLEN-1:0] w_inst_rdata;
  logic            w_ren;
  logic            w_wen;
  logic [11:0]     w_addr;
  logic [XLEN-1:0] w_wdata;
  logic            w_busy;
  logic            w_redir;

  assign w_irq       = i_clint_mtip & i_mstatus_mie & i_mie_mtie;
  assign w_take_trap = w_irq | i_ecall;

  always_comb begin
    w_mst_trap                        = r_mst;
    w_mst_trap[MST_MPIE]              = r_mst[MST_MIE];
    w_mst_trap[MST_MIE]               = 1'b0;
    w_mst_trap[MST_MPP_HI:MST_MPP_LO] = 2'b11;
  end

  always_comb begin
    w_mst_ret                        = r_mst;
    w_mst_ret[MST_MIE]               = r_mst[MST_MPIE];
    w_mst_ret[MST_MPIE]              = 1'b1;
    w_mst_ret[MST_MPP_HI:MST_MPP_LO] = 2'b11;
  end

  always_comb begin
    w_state_d    = r_state;
    w_inst_rdata = '0;
    w_ren        = 1'b0;
    w_wen        = 1'b0;
    w_addr       = 12'h000;
    w_wdata      = '0;
    w_busy       = 1'b1;
    w_redir      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_take_trap) begin
          w_state_d = S_T_RD_MST;
        end else if (i_mret) begin
          w_state_d = S_R_RD_MST;
        end else begin
          w_ren        = i_inst_csr_ren;
          w_wen        = i_inst_csr_wen;
          w_addr       = i_inst_csr_addr;
          w_wdata      = i_inst_csr_wdata;
          w_inst_rdata = i_csr_rdata;
        end
      end
      S_T_RD_MST: begin
        w_ren     = 1'b1;
        w_addr    = CSR_MSTATUS;
        w_state_d = S_T_WR_EPC;
      end
      S_T_WR_EPC: begin
        w_wen     = 1'b1;
        w_addr    = CSR_MEPC;
        w_wdata   = r_pc;
        w_state_d = S_T_WR_CAU;
      end
      S_T_WR_CAU: begin
        w_wen     = 1'b1;
        w_addr    = CSR_MCAUSE;
        w_wdata   = r_cause;
        w_state_d = S_T_WR_MST;
      end
      S_T_WR_MST: begin
        w_wen     = 1'b1;
        w_addr    = CSR_MSTATUS;
        w_wdata   = w_mst_trap;
        w_state_d = S_T_RD_TVEC;
      end
      S_T_RD_TVEC: begin
        w_ren     = 1'b1;
        w_addr    = CSR_MTVEC;
        w_state_d = S_DONE;
      end
      S_R_RD_MST: begin
        w_ren     = 1'b1;
        w_addr    = CSR_MSTATUS;
        w_state_d = S_R_WR_MST;
      end
      S_R_WR_MST: begin
        w_wen     = 1'b1;
        w_addr    = CSR_MSTATUS;
        w_wdata   = w_mst_ret;
        w_state_d = S_R_RD_EPC;
      end
      S_R_RD_EPC: begin
        w_ren     = 1'b1;
        w_addr    = CSR_MEPC;
        w_state_d = S_DONE;
      end
      S_DONE: begin
        w_redir   = 1'b1;
        w_state_d = S_IDLE;
      end
      default: begin
        w_busy    = 1'b0;
        w_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cause <= '0;
      r_mst   <= '0;
      r_tgt   <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == S_IDLE && w_take_trap) begin
        r_pc    <= i_pc;
        // Interrupt wins over a simultaneous ecall; the ecall re-executes later.
        r_cause <= w_irq ? CAUSE_MTI : CAUSE_ECALL_M;
      end
      if (r_state == S_T_RD_MST || r_state == S_R_RD_MST) begin
        r_mst <= i_csr_rdata;
      end
      if (r_state == S_T_RD_TVEC) begin
        // Direct mode only: mode bits are dropped.
        r_tgt <= {i_csr_rdata[XLEN-1:2], 2'b00};
      end else if (r_state == S_R_RD_EPC) begin
        r_tgt <= i_csr_rdata;
      end
    end
  end

  always_comb begin
    if (rst) begin
      o_inst_csr_rdata = '0;
      o_csr_ren        = 1'b0;
      o_csr_wen        = 1'b0;
      o_csr_addr       = 12'h000;
      o_csr_wdata      = '0;
      o_busy           = 1'b0;
      o_redirect_valid = 1'b0;
      o_redirect_pc    = '0;
    end else begin
      o_inst_csr_rdata = w_inst_rdata;
      o_csr_ren        = w_ren;
      o_csr_wen        = w_wen;
      o_csr_addr       = w_addr;
      o_csr_wdata      = w_wdata;
      o_busy           = w_busy;
      o_redirect_valid = w_redir;
      o_redirect_pc    = r_tgt;
    end
  end

endmodule

// File: tb/tb_ysyx_210544_csr_trap_seq.sv
module tb_ysyx_210544_csr_trap_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_pc;
  logic        i_ecall;
  logic        i_mret;
  logic        i_clint_mtip;
  logic        i_mstatus_mie;
  logic        i_mie_mtie;
  logic        i_inst_csr_ren;
  logic        i_inst_csr_wen;
  logic [11:0] i_inst_csr_addr;
  logic [63:0] i_inst_csr_wdata;
  logic [63:0] o_inst_csr_rdata;
  logic        o_csr_ren;
  logic        o_csr_wen;
  logic [11:0] o_csr_addr;
  logic [63:0] o_csr_wdata;
  logic [63:0] i_csr_rdata;
  logic        o_busy;
  logic        o_redirect_valid;
  logic [63:0] o_redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  // Small CSR file model, not touched by rst.
  logic [63:0] m_mstatus  = 64'h0;
  logic [63:0] m_mie      = 64'h0;
  logic [63:0] m_mtvec    = 64'h0;
  logic [63:0] m_mepc     = 64'h0;
  logic [63:0] m_mcause   = 64'h0;
  logic [63:0] m_mscratch = 64'h0;

  always #5 clk = ~clk;

  ysyx_210544_csr_trap_seq dut (
    .clk              (clk),
    .rst              (rst),
    .i_pc             (i_pc),
    .i_ecall          (i_ecall),
    .i_mret           (i_mret),
    .i_clint_mtip     (i_clint_mtip),
    .i_mstatus_mie    (i_mstatus_mie),
    .i_mie_mtie       (i_mie_mtie),
    .i_inst_csr_ren   (i_inst_csr_ren),
    .i_inst_csr_wen   (i_inst_csr_wen),
    .i_inst_csr_addr  (i_inst_csr_addr),
    .i_inst_csr_wdata (i_inst_csr_wdata),
    .o_inst_csr_rdata (o_inst_csr_rdata),
    .o_csr_ren        (o_csr_ren),
    .o_csr_wen        (o_csr_wen),
    .o_csr_addr       (o_csr_addr),
    .o_csr_wdata      (o_csr_wdata),
    .i_csr_rdata      (i_csr_rdata),
    .o_busy           (o_busy),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc)
  );

  assign i_mstatus_mie = m_mstatus[3];
  assign i_mie_mtie    = m_mie[7];

  always_comb begin
    i_csr_rdata = 64'h0;
    case (o_csr_addr)
      12'h300: i_csr_rdata = m_mstatus;
      12'h304: i_csr_rdata = m_mie;
      12'h305: i_csr_rdata = m_mtvec;
      12'h340: i_csr_rdata = m_mscratch;
      12'h341: i_csr_rdata = m_mepc;
      12'h342: i_csr_rdata = m_mcause;
      default: i_csr_rdata = 64'h0;
    endcase
  end

  always @(posedge clk) begin
    if (o_csr_wen) begin
      case (o_csr_addr)
        12'h300: m_mstatus  <= o_csr_wdata;
        12'h304: m_mie      <= o_csr_wdata;
        12'h305: m_mtvec    <= o_csr_wdata;
        12'h340: m_mscratch <= o_csr_wdata;
        12'h341: m_mepc     <= o_csr_wdata;
        12'h342: m_mcause   <= o_csr_wdata;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [63:0] data);
    i_inst_csr_wen   = 1'b1;
    i_inst_csr_addr  = addr;
    i_inst_csr_wdata = data;
    tick();
    i_inst_csr_wen   = 1'b0;
  endtask

  // Called in the accept cycle; returns in the DONE cycle. Events are dropped
  // after the accept edge so they are not re-taken on return to IDLE.
  task automatic run_seq(input string tag, input int n, input logic [63:0] exp_pc);
    for (int k = 1; k <= n; k++) begin
      tick();
      i_ecall      = 1'b0;
      i_mret       = 1'b0;
      i_clint_mtip = 1'b0;
      #1;
      check({tag, "_busy"}, {63'd0, o_busy}, 64'd1);
      check({tag, "_redir_v"}, {63'd0, o_redirect_valid}, (k == n) ? 64'd1 : 64'd0);
    end
    check({tag, "_redir_pc"}, o_redirect_pc, exp_pc);
  endtask

  initial begin
    rst              = 1'b1;
    i_pc             = 64'h0;
    i_ecall          = 1'b0;
    i_mret           = 1'b0;
    i_clint_mtip     = 1'b0;
    i_inst_csr_ren   = 1'b1;
    i_inst_csr_wen   = 1'b1;
    i_inst_csr_addr  = 12'h340;
    i_inst_csr_wdata = 64'h77;
    #3;
    check("rst_wen",   {63'd0, o_csr_wen}, 64'd0);
    check("rst_ren",   {63'd0, o_csr_ren}, 64'd0);
    check("rst_addr",  {52'd0, o_csr_addr}, 64'd0);
    check("rst_busy",  {63'd0, o_busy}, 64'd0);
    check("rst_rpc",   o_redirect_pc, 64'd0);
    i_inst_csr_ren = 1'b0;
    i_inst_csr_wen = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Pass-through write and read of mscratch.
    i_inst_csr_wen   = 1'b1;
    i_inst_csr_addr  = 12'h340;
    i_inst_csr_wdata = 64'h55;
    #1;
    check("pt_wen",   {63'd0, o_csr_wen}, 64'd1);
    check("pt_addr",  {52'd0, o_csr_addr}, 64'h340);
    check("pt_wdata", o_csr_wdata, 64'h55);
    check("pt_busy",  {63'd0, o_busy}, 64'd0);
    tick();
    i_inst_csr_wen = 1'b0;
    i_inst_csr_ren = 1'b1;
    #1;
    check("pt_rdata", o_inst_csr_rdata, 64'h55);
    i_inst_csr_ren = 1'b0;

    csr_write(12'h300, 64'h1808);
    csr_write(12'h304, 64'h80);
    csr_write(12'h305, 64'h8000_1000);

    // Timer interrupt entry.
    i_pc         = 64'h8000_0040;
    i_clint_mtip = 1'b1;
    #1;
    check("irq_acc_wen",  {63'd0, o_csr_wen}, 64'd0);
    check("irq_acc_ren",  {63'd0, o_csr_ren}, 64'd0);
    check("irq_acc_busy", {63'd0, o_busy}, 64'd0);
    run_seq("irq", 6, 64'h8000_1000);
    tick();
    check("irq_idle_busy", {63'd0, o_busy}, 64'd0);
    check("irq_idle_rv",   {63'd0, o_redirect_valid}, 64'd0);
    check("irq_hold_rpc",  o_redirect_pc, 64'h8000_1000);
    check("irq_mepc",      m_mepc, 64'h8000_0040);
    check("irq_mcause",    m_mcause, 64'h8000_0000_0000_0007);
    check("irq_mstatus",   m_mstatus, 64'h1880);

    // mret back to the interrupted PC.
    i_mret = 1'b1;
    #1;
    check("mret_acc_wen", {63'd0, o_csr_wen}, 64'd0);
    run_seq("mret", 4, 64'h8000_0040);
    tick();
    check("mret_mstatus", m_mstatus, 64'h1888);
    check("mret_idle",    {63'd0, o_busy}, 64'd0);

    // ecall with mode bits set in mtvec.
    csr_write(12'h305, 64'h8000_2003);
    i_pc    = 64'h8000_0100;
    i_ecall = 1'b1;
    #1;
    run_seq("ecall", 6, 64'h8000_2000);
    tick();
    check("ecall_mcause",  m_mcause, 64'd11);
    check("ecall_mepc",    m_mepc, 64'h8000_0100);
    check("ecall_mstatus", m_mstatus, 64'h1880);

    // irq and ecall together, with a pipeline write held during the sequence.
    csr_write(12'h300, 64'h1808);
    i_pc             = 64'h8000_0200;
    i_clint_mtip     = 1'b1;
    i_ecall          = 1'b1;
    i_inst_csr_wen   = 1'b1;
    i_inst_csr_addr  = 12'h340;
    i_inst_csr_wdata = 64'hAA;
    #1;
    run_seq("prio", 6, 64'h8000_2000);
    i_inst_csr_wen = 1'b0;
    tick();
    check("prio_mcause",   m_mcause, 64'h8000_0000_0000_0007);
    check("prio_mepc",     m_mepc, 64'h8000_0200);
    check("prio_mscratch", m_mscratch, 64'h55);

    // Reset in the middle of an ecall sequence, in the mcause write cycle.
    i_pc    = 64'h8000_0300;
    i_ecall = 1'b1;
    #1;
    tick();
    i_ecall = 1'b0;
    tick();
    tick();
    check("mid_addr", {52'd0, o_csr_addr}, 64'h342);
    rst = 1'b1;
    #1;
    check("mid_rst_wen",  {63'd0, o_csr_wen}, 64'd0);
    check("mid_rst_addr", {52'd0, o_csr_addr}, 64'd0);
    check("mid_rst_busy", {63'd0, o_busy}, 64'd0);
    check("mid_rst_rpc",  o_redirect_pc, 64'd0);
    tick();
    check("mid_mcause", m_mcause, 64'h8000_0000_0000_0007);
    rst = 1'b0;
    tick();
    check("post_rst_busy", {63'd0, o_busy}, 64'd0);
    i_inst_csr_ren  = 1'b1;
    i_inst_csr_addr = 12'h340;
    #1;
    check("post_rst_rdata", o_inst_csr_rdata, 64'h55);
    i_inst_csr_ren = 1'b0;
    tick();
    check("post_rst_rv", {63'd0, o_redirect_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
